// File: rtl/sd_sector_arbiter_pkg.sv
// Shared types for the SD sector arbiter: the FSM state enum, the default watchdog
// limit and an index-width helper that never returns zero.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    DONE
  } sd_arb_state_t;

  localparam logic [21:0] DEFAULT_TIMEOUT = 22'h3FFFFF;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_sector_arbiter_if.sv
// Bundle of requester-side and sd_reader-side signals around the sector arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface sd_sector_arbiter_if #(
  parameter int NUM_REQ = 2
);

  logic                    card_ready;
  logic [NUM_REQ-1:0]      req_rd;
  logic [32*NUM_REQ-1:0]   req_lba;
  logic [NUM_REQ-1:0]      req_ack;
  logic [NUM_REQ-1:0]      req_done;
  logic [NUM_REQ-1:0]      req_err;
  logic [8:0]              buf_addr;
  logic [7:0]              buf_data;
  logic [NUM_REQ-1:0]      buf_strobe;
  logic                    rstart;
  logic [31:0]             rsector;
  logic                    rbusy;
  logic                    rdone;
  logic                    outen;
  logic [8:0]              outaddr;
  logic [7:0]              outbyte;
  logic                    active;

  modport master (
    input  card_ready, req_rd, req_lba, rbusy, rdone, outen, outaddr, outbyte,
    output req_ack, req_done, req_err, buf_addr, buf_data, buf_strobe,
           rstart, rsector, active
  );

  modport slave (
    output card_ready, req_rd, req_lba, rbusy, rdone, outen, outaddr, outbyte,
    input  req_ack, req_done, req_err, buf_addr, buf_data, buf_strobe,
           rstart, rsector, active
  );

endinterface

// File: rtl/sd_sector_arbiter_rr_picker.sv
// Combinational round-robin select: first set request strictly after i_last,
// wrapping by explicit compare so non-power-of-2 requester counts work.
module rr_picker
  import sd_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [IW-1:0]      o_winner,
  output logic               o_valid
);

  logic [IW-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = i_last;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_idx == IW'(NUM_REQ - 1)) begin
        w_idx = '0;
      end else begin
        w_idx = w_idx + IW'(1);
      end
      if (!o_valid && i_req[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Round-robin sharing of one sd_reader between NUM_REQ sector requesters.
// Optional watchdog abort is enabled by defining SD_ARB_TIMEOUT_EN.
module sd_sector_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NUM_REQ = 2,
  parameter logic [21:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk_32,
  input  logic                reset,
  sd_sector_arbiter_if.master bus
);

  localparam int IW = idxWidth(NUM_REQ);

  sd_arb_state_t      r_state;
  sd_arb_state_t      w_next;
  logic [IW-1:0]      r_grant;
  logic [IW-1:0]      r_lastGrant;
  logic [31:0]        r_rsector;
  logic [8:0]         r_bufAddr;
  logic [7:0]         r_bufData;
  logic [NUM_REQ-1:0] r_bufStrobe;
  logic [IW-1:0]      w_winner;
  logic               w_valid;
  logic               w_take;
  logic               w_expire;
  logic               w_owning;
  logic [NUM_REQ-1:0] w_grantOneHot;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req    (bus.req_rd),
    .i_last   (r_lastGrant),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_grantOneHot = NUM_REQ'(1) << r_grant;
  assign w_owning      = (r_state == START) || (r_state == BUSY);

  always_ff @(posedge clk_32) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Timeout has priority over rdone so an abort is never reported as a clean sector.
  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.card_ready && !bus.rbusy && w_valid) begin
          w_take = 1'b1;
          w_next = START;
        end
      end
      START: begin
        if (w_expire || bus.rdone) w_next = DONE;
        else if (bus.rbusy)        w_next = BUSY;
      end
      BUSY:    if (w_expire || bus.rdone) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_32) begin
    if (reset) begin
      r_grant     <= '0;
      r_lastGrant <= IW'(NUM_REQ - 1);
      r_rsector   <= '0;
    end else if (w_take) begin
      r_grant     <= w_winner;
      r_lastGrant <= w_winner;
      r_rsector   <= bus.req_lba[{w_winner, 5'd0} +: 32];
    end
  end

  always_ff @(posedge clk_32) begin
    if (reset) begin
      r_bufAddr   <= '0;
      r_bufData   <= '0;
      r_bufStrobe <= '0;
    end else begin
      if (bus.outen) begin
        r_bufAddr <= bus.outaddr;
        r_bufData <= bus.outbyte;
      end
      r_bufStrobe <= (bus.outen && w_owning) ? w_grantOneHot : '0;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [21:0] r_timer;
  logic        r_abort;

  assign w_expire = w_owning && (r_timer == TIMEOUT - 22'd1);

  always_ff @(posedge clk_32) begin
    if (reset) begin
      r_timer <= '0;
      r_abort <= 1'b0;
    end else if (w_take) begin
      r_timer <= '0;
      r_abort <= 1'b0;
    end else if (w_owning) begin
      r_timer <= r_timer + 22'd1;
      if (w_expire) r_abort <= 1'b1;
    end
  end

  assign bus.req_err = (r_state == DONE && r_abort) ? w_grantOneHot : '0;
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = ^TIMEOUT;
  assign w_expire        = 1'b0;
  assign bus.req_err     = '0;
`endif

  assign bus.req_ack    = (r_state != IDLE)  ? w_grantOneHot : '0;
  assign bus.req_done   = (r_state == DONE)  ? w_grantOneHot : '0;
  assign bus.rstart     = (r_state == START);
  assign bus.active     = (r_state != IDLE);
  assign bus.rsector    = r_rsector;
  assign bus.buf_addr   = r_bufAddr;
  assign bus.buf_data   = r_bufData;
  assign bus.buf_strobe = r_bufStrobe;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed self-checking bench for sd_sector_arbiter with two requesters.
// When built with SD_ARB_TIMEOUT_EN it also exercises the 1000-cycle watchdog.
module tb_sd_sector_arbiter;
  import sd_arb_pkg::*;

  localparam logic [31:0] Lba0 = 32'h0000_0123;
  localparam logic [31:0] Lba1 = 32'h0000_ABCD;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sd_sector_arbiter_if #(.NUM_REQ(2)) bus ();

  sd_sector_arbiter #(.NUM_REQ(2), .TIMEOUT(22'd1000)) dut (
    .clk_32 (clk),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global guard so a broken DUT can never hang the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cr, input logic [1:0] rd,
                               input logic busy, input logic done);
    bus.card_ready = cr;
    bus.req_rd     = rd;
    bus.rbusy      = busy;
    bus.rdone      = done;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Caller has just observed START for the owner; drive a short sector to completion.
  task automatic finishSector(input logic [1:0] own);
    bus.rbusy = 1'b1;
    tick();
    checkOutput("busy_ack", bus.req_ack, own);
    checkOutput("busy_rstart", bus.rstart, 0);
    bus.rbusy = 1'b0;
    bus.rdone = 1'b1;
    tick();
    checkOutput("done_pulse", bus.req_done, own);
    checkOutput("done_ack", bus.req_ack, own);
    checkOutput("done_err", bus.req_err, 0);
    bus.rdone = 1'b0;
    tick();
    checkOutput("idle_ack", bus.req_ack, 0);
    checkOutput("idle_done", bus.req_done, 0);
  endtask

  initial begin
    logic [18:0] expByte;
    logic        sawStart;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    bus.req_lba = {Lba1, Lba0};
    bus.outen   = 1'b0;
    bus.outaddr = '0;
    bus.outbyte = '0;

    doReset();
    checkOutput("rst_ack", bus.req_ack, 0);
    checkOutput("rst_rstart", bus.rstart, 0);
    checkOutput("rst_rsector", bus.rsector, 0);
    checkOutput("rst_active", bus.active, 0);
    checkOutput("rst_strobe", bus.buf_strobe, 0);
    checkOutput("rst_addr", bus.buf_addr, 0);

    $display("[TB] single request");
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    tick();
    checkOutput("single_rstart", bus.rstart, 1);
    checkOutput("single_ack", bus.req_ack, 2'b01);
    checkOutput("single_rsector", bus.rsector, Lba0);
    checkOutput("single_active", bus.active, 1);
    bus.req_rd  = 2'b00;
    bus.req_lba = {Lba1, 32'h0000_0999};
    finishSector(2'b01);
    checkOutput("single_latched", bus.rsector, Lba0);
    bus.req_lba = {Lba1, Lba0};

    $display("[TB] contention");
    doReset();
    bus.req_rd = 2'b11;
    for (int s = 0; s < 4; s++) begin
      tick();
      checkOutput("rr_ack", bus.req_ack, (s % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput("rr_rsector", bus.rsector, (s % 2 == 0) ? Lba0 : Lba1);
      finishSector((s % 2 == 0) ? 2'b01 : 2'b10);
    end
    bus.req_rd = 2'b00;

    $display("[TB] byte routing");
    bus.req_rd = 2'b10;
    tick();
    checkOutput("route_ack", bus.req_ack, 2'b10);
    bus.req_rd = 2'b00;
    bus.rbusy  = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) begin
      bus.outen   = 1'b1;
      bus.outaddr = 9'(i);
      bus.outbyte = 8'(i) ^ 8'hA5;
      tick();
      expByte = {2'b10, 9'(i), 8'(i) ^ 8'hA5};
      checkOutput("route_byte", {bus.buf_strobe, bus.buf_addr, bus.buf_data}, expByte);
    end
    bus.outen = 1'b0;
    tick();
    checkOutput("route_idle_strobe", bus.buf_strobe, 0);
    bus.rbusy = 1'b0;
    bus.rdone = 1'b1;
    tick();
    checkOutput("route_done", bus.req_done, 2'b10);
    bus.rdone = 1'b0;
    tick();
    checkOutput("route_end_ack", bus.req_ack, 0);

    $display("[TB] card_ready gating");
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    sawStart = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.rstart !== 1'b0) sawStart = 1'b1;
    end
    checkOutput("gate_no_start", sawStart, 0);
    bus.card_ready = 1'b1;
    tick();
    checkOutput("gate_rstart", bus.rstart, 1);
    checkOutput("gate_ack", bus.req_ack, 2'b01);
    bus.req_rd = 2'b00;
    finishSector(2'b01);

    $display("[TB] reset mid-transfer");
    bus.req_rd = 2'b10;
    tick();
    checkOutput("orphan_ack", bus.req_ack, 2'b10);
    bus.req_rd = 2'b00;
    bus.rbusy  = 1'b1;
    tick();
    for (int i = 0; i < 200; i++) begin
      bus.outen   = 1'b1;
      bus.outaddr = 9'(i);
      bus.outbyte = 8'(i);
      tick();
    end
    reset       = 1'b1;
    bus.outaddr = 9'd200;
    bus.outbyte = 8'd200;
    tick();
    checkOutput("mid_rst_ack", bus.req_ack, 0);
    checkOutput("mid_rst_active", bus.active, 0);
    checkOutput("mid_rst_strobe", bus.buf_strobe, 0);
    checkOutput("mid_rst_addr", bus.buf_addr, 0);
    reset      = 1'b0;
    bus.req_rd = 2'b01;
    for (int i = 201; i < 221; i++) begin
      bus.outaddr = 9'(i);
      bus.outbyte = 8'(i);
      tick();
      checkOutput("orphan_strobe", bus.buf_strobe, 0);
      checkOutput("orphan_no_grant", bus.req_ack, 0);
    end
    bus.outen = 1'b0;
    bus.rbusy = 1'b0;
    tick();
    checkOutput("post_rst_ack", bus.req_ack, 2'b01);
    checkOutput("post_rst_rsector", bus.rsector, Lba0);
    bus.req_rd = 2'b00;
    finishSector(2'b01);

`ifdef SD_ARB_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    bus.req_rd = 2'b01;
    tick();
    checkOutput("to_ack", bus.req_ack, 2'b01);
    bus.req_rd = 2'b00;
    bus.rbusy  = 1'b1;
    sawStart   = 1'b0;
    for (int k = 1; k < 1000; k++) begin
      tick();
      if (bus.req_err !== 2'b00 || bus.req_done !== 2'b00) sawStart = 1'b1;
    end
    checkOutput("to_early", sawStart, 0);
    tick();
    checkOutput("to_err", bus.req_err, 2'b01);
    checkOutput("to_done", bus.req_done, 2'b01);
    checkOutput("to_rstart", bus.rstart, 0);
    bus.rbusy  = 1'b0;
    bus.req_rd = 2'b10;
    tick();
    checkOutput("to_err_clear", bus.req_err, 0);
    checkOutput("to_idle_ack", bus.req_ack, 0);
    tick();
    checkOutput("to_next_ack", bus.req_ack, 2'b10);
    bus.req_rd = 2'b00;
    finishSector(2'b10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
